// File: rtl/aes_ks_pkg.sv
// Shared types and constants for the AES key-schedule controller.
// Round numbers are 4 bits; anything above MAX_ROUND is answered with an error response.
package aes_ks_pkg;

    localparam int         AES_NUM_ROUNDS = 10;
    localparam logic [3:0] MAX_ROUND      = 4'(AES_NUM_ROUNDS);

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_key_t;

    typedef enum logic [2:0] {
        LIDLE, LSTART, LW0, LW1, LW2, LW3, LEXP, LRDY
    } load_state_t;

    typedef enum logic [2:0] {
        FIDLE, F0, F1, F2, F3, FRSP
    } fetch_state_t;

    // Word 0 sits in the most significant 32 bits of a 128-bit key.
    function automatic aes_word_t key_word(input aes_key_t k, input logic [1:0] idx);
        return k[127 - 32 * int'(idx) -: 32];
    endfunction

endpackage

// File: rtl/ksc_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at the stored pointer.
// Pointer moves past the winner only when adv is high and something was granted.
module ksc_rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             adv,
    output logic [N_REQ-1:0] gnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt_ptr;
    logic          found;
    int            idx;

    always_comb begin
        gnt     = '0;
        nxt_ptr = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                nxt_ptr  = PW'((idx + 1) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr <= '0;
        else if (adv && found)
            ptr <= nxt_ptr;
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Loads a cipher key into key_expand, then serves round-key fetches: response 5 cycles after grant (1 for a bad round).
// No response backpressure; optional expansion watchdog under KSC_WATCHDOG_EN.
module aes_key_sched_ctrl
    import aes_ks_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int WDOG_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [127:0]       key_in,
    output logic               key_ready,
    output logic               key_loaded,
    output logic               key_err,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [4*N_REQ-1:0] req_round,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [127:0]       rsp_key,
    output logic               rsp_err,
    output logic               ke_start,
    output logic [31:0]        ke_cipher_key,
    output logic [3:0]         ke_round_key_num,
    output logic [1:0]         ke_r_index,
    input  logic [31:0]        ke_round_key,
    input  logic               ke_done
);

    load_state_t      lstate, lnext;
    fetch_state_t     fstate, fnext;
    aes_key_t         key_q;
    logic [3:0]       round_q;
    logic [3:0]       sel_round;
    logic [N_REQ-1:0] gnt;
    logic [N_REQ-1:0] gnt_q;
    logic             err_q;
    logic             key_acc;
    logic             grant_en;
    logic             wdog_exp;

    // A pending key takes priority over every fetch request.
    assign key_ready  = !reset && ((lstate == LIDLE) || (lstate == LRDY && fstate == FIDLE));
    assign key_acc    = key_valid && key_ready;
    assign grant_en   = (lstate == LRDY) && (fstate == FIDLE) && !key_valid;
    assign key_loaded = (lstate == LRDY);
    assign req_ready  = gnt;

    ksc_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid & {N_REQ{grant_en}}),
        .adv   (grant_en),
        .gnt   (gnt)
    );

    always_comb begin
        sel_round = '0;
        for (int i = 0; i < N_REQ; i++)
            if (gnt[i]) sel_round = req_round[4*i +: 4];
    end

`ifdef KSC_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wdog_cnt <= '0;
        else if (lstate == LEXP)
            wdog_cnt <= wdog_cnt + 1'b1;
        else
            wdog_cnt <= '0;
    end

    assign wdog_exp = (lstate == LEXP) && !ke_done && (wdog_cnt == WW'(WDOG_CYCLES - 1));
`else
    assign wdog_exp = 1'b0;
`endif

    assign key_err = wdog_exp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lstate <= LIDLE;
            fstate <= FIDLE;
        end else begin
            lstate <= lnext;
            fstate <= fnext;
        end
    end

    always_comb begin
        lnext         = lstate;
        ke_start      = 1'b0;
        ke_cipher_key = '0;
        case (lstate)
            LIDLE:  if (key_acc) lnext = LSTART;
            LSTART: begin ke_start = 1'b1; lnext = LW0; end
            LW0:    begin ke_cipher_key = key_word(key_q, 2'd0); lnext = LW1; end
            LW1:    begin ke_cipher_key = key_word(key_q, 2'd1); lnext = LW2; end
            LW2:    begin ke_cipher_key = key_word(key_q, 2'd2); lnext = LW3; end
            LW3:    begin ke_cipher_key = key_word(key_q, 2'd3); lnext = LEXP; end
            LEXP: begin
                if (ke_done)       lnext = LRDY;
                else if (wdog_exp) lnext = LIDLE;
            end
            LRDY:   if (key_acc) lnext = LSTART;
            default: lnext = LIDLE;
        endcase
    end

    always_comb begin
        fnext            = fstate;
        ke_round_key_num = '0;
        ke_r_index       = '0;
        rsp_valid        = '0;
        rsp_err          = 1'b0;
        case (fstate)
            FIDLE: if (|gnt) fnext = (sel_round > MAX_ROUND) ? FRSP : F0;
            F0:    begin ke_round_key_num = round_q; ke_r_index = 2'd0; fnext = F1; end
            F1:    begin ke_round_key_num = round_q; ke_r_index = 2'd1; fnext = F2; end
            F2:    begin ke_round_key_num = round_q; ke_r_index = 2'd2; fnext = F3; end
            F3:    begin ke_round_key_num = round_q; ke_r_index = 2'd3; fnext = FRSP; end
            FRSP:  begin rsp_valid = gnt_q; rsp_err = err_q; fnext = FIDLE; end
            default: fnext = FIDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            key_q <= '0;
        else if (key_acc)
            key_q <= key_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_q   <= '0;
            round_q <= '0;
            err_q   <= 1'b0;
            rsp_key <= '0;
        end else begin
            if (fstate == FIDLE && |gnt) begin
                gnt_q   <= gnt;
                round_q <= sel_round;
                err_q   <= (sel_round > MAX_ROUND);
                if (sel_round > MAX_ROUND) rsp_key <= '0;
            end
            case (fstate)
                F0: rsp_key[127:96] <= ke_round_key;
                F1: rsp_key[95:64]  <= ke_round_key;
                F2: rsp_key[63:32]  <= ke_round_key;
                F3: rsp_key[31:0]   <= ke_round_key;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural key_expand with a real AES-128 schedule and a response scoreboard.
module tb_aes_key_sched_ctrl;

    localparam int N_REQ = 2;
    localparam logic [127:0] KEY1 = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam int EXP_DLY = 7;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               key_valid = 1'b0;
    logic [127:0]       key_in = '0;
    logic               key_ready, key_loaded, key_err;
    logic [N_REQ-1:0]   req_valid = '0;
    logic [4*N_REQ-1:0] req_round = '0;
    logic [N_REQ-1:0]   req_ready, rsp_valid;
    logic [127:0]       rsp_key;
    logic               rsp_err;
    logic               ke_start;
    logic [31:0]        ke_cipher_key;
    logic [3:0]         ke_round_key_num;
    logic [1:0]         ke_r_index;
    logic [31:0]        ke_round_key;
    logic               ke_done;

    always #5 clk = ~clk;

    aes_key_sched_ctrl #(.N_REQ(N_REQ), .WDOG_CYCLES(1023)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_in(key_in),
        .key_ready(key_ready), .key_loaded(key_loaded), .key_err(key_err),
        .req_valid(req_valid), .req_round(req_round), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_key(rsp_key), .rsp_err(rsp_err),
        .ke_start(ke_start), .ke_cipher_key(ke_cipher_key),
        .ke_round_key_num(ke_round_key_num), .ke_r_index(ke_r_index),
        .ke_round_key(ke_round_key), .ke_done(ke_done)
    );

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- AES-128 reference schedule ----------------
    logic [7:0] sb_tab [0:255];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    endfunction

    initial for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));

    function automatic logic [127:0] aes_rk(input logic [127:0] key, input int rnd);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]], sb_tab[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
    endfunction

    // ---------------- behavioural key_expand ----------------
    logic [31:0]  kw [0:3];
    logic [127:0] sched [0:10];
    int           kcnt;
    bit           hang = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ke_done <= 1'b0;
            kcnt    <= 0;
        end else if (ke_start) begin
            ke_done <= 1'b0;
            kcnt    <= 1;
        end else if (kcnt >= 1 && kcnt <= 4) begin
            kw[kcnt-1] <= ke_cipher_key;
            kcnt       <= kcnt + 1;
        end else if (kcnt >= 5 && kcnt < 5 + EXP_DLY) begin
            kcnt <= kcnt + 1;
        end else if (kcnt == 5 + EXP_DLY) begin
            for (int r = 0; r <= 10; r++) sched[r] <= aes_rk({kw[0], kw[1], kw[2], kw[3]}, r);
            if (!hang) ke_done <= 1'b1;
            kcnt <= 0;
        end
    end

    always_comb begin
        ke_round_key = 32'h0;
        if (ke_round_key_num <= 4'd10)
            ke_round_key = sched[ke_round_key_num][127 - 32*int'(ke_r_index) -: 32];
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int           req;
        logic         err;
        logic [127:0] key;
        int           due;
    } exp_t;

    exp_t         sb [$];
    int           hs_req [$];
    int           hs_cyc [$];
    logic [127:0] cur_key = '0;
    logic [127:0] last_rsp_key = '0;
    exp_t         mon_e;
    logic [3:0]   mon_r;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    mon_r     = req_round[4*i +: 4];
                    mon_e.req = i;
                    mon_e.err = (mon_r > 4'd10);
                    mon_e.key = mon_e.err ? 128'h0 : aes_rk(cur_key, int'(mon_r));
                    mon_e.due = cyc + (mon_e.err ? 1 : 5);
                    sb.push_back(mon_e);
                    hs_req.push_back(i);
                    hs_cyc.push_back(cyc);
                end
            end
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 128'(rsp_valid), 128'h0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_who", 128'(rsp_valid), 128'(1) << mon_e.req);
                    chk("rsp_key", rsp_key, mon_e.key);
                    chk("rsp_err", 128'(rsp_err), 128'(mon_e.err));
                    chk("rsp_latency", 128'(cyc), 128'(mon_e.due));
                    last_rsp_key = rsp_key;
                end
            end
        end
    end

    // ---------------- tasks ----------------
    task automatic wait_drain();
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain", 128'(sb.size()), 128'h0);
    endtask

    task automatic load_key(input logic [127:0] k, input bit wait_loaded);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (key_ready) break;
        end
        @(posedge clk); #1;
        key_valid = 1'b1;
        key_in    = k;
        @(negedge clk);
        chk("key_ready", 128'(key_ready), 128'h1);
        @(posedge clk);
        cur_key = k;
        #1 key_valid = 1'b0;
        @(negedge clk);
        chk("ke_start", 128'(ke_start), 128'h1);
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            chk("ke_cipher_key", 128'(ke_cipher_key), 128'(k[127 - 32*w -: 32]));
            chk("ke_start_once", 128'(ke_start), 128'h0);
        end
        if (wait_loaded) begin
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (key_loaded) break;
            end
            chk("key_loaded", 128'(key_loaded), 128'h1);
        end
    endtask

    task automatic fetch(input int idx, input logic [3:0] r);
        @(posedge clk); #1;
        req_valid[idx]        = 1'b1;
        req_round[4*idx +: 4] = r;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_ready[idx]) break;
        end
        chk("grant", 128'(req_ready[idx]), 128'h1);
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
        wait_drain();
    endtask

    task automatic all_outs_zero(input string tag);
        chk(tag, {key_ready, key_loaded, key_err, req_ready, rsp_valid, rsp_err, ke_start,
                  ke_cipher_key, ke_round_key_num, ke_r_index}, 128'h0);
        chk({tag, "_rsp_key"}, rsp_key, 128'h0);
    endtask

    // ---------------- main sequence ----------------
    int base;
    int n;
    int stall_bad;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        all_outs_zero("reset_outs");
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 128'(key_ready), 128'h1);

        load_key(KEY1, 1'b1);

        fetch(0, 4'd0);
        chk("r0_const", last_rsp_key, KEY1);
        fetch(0, 4'd1);
        chk("r1_const", last_rsp_key, 128'he232fcf191129188b159e4e6d679a293);
        fetch(0, 4'd10);
        chk("r10_const", last_rsp_key, 128'h28fddef86da4244accc0a4fe3b316f26);

        // out-of-range round: immediate error response, no read sweep
        @(posedge clk); #1;
        req_valid[1]   = 1'b1;
        req_round[7:4] = 4'd12;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready[1]) break;
        end
        @(posedge clk); #1 req_valid[1] = 1'b0;
        @(negedge clk);
        chk("err_rsp_valid", 128'(rsp_valid), 128'h2);
        chk("err_no_sweep", {ke_round_key_num, ke_r_index}, 128'h0);
        wait_drain();

        // both requesters held continuously: alternate grants, one per 6 cycles
        base = hs_req.size();
        @(posedge clk); #1;
        req_round = {4'd7, 4'd3};
        req_valid = 2'b11;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (hs_req.size() >= base + 4) break;
        end
        @(posedge clk); #1 req_valid = '0;
        wait_drain();
        chk("alt_count", 128'(hs_req.size() - base >= 4), 128'h1);
        for (int k = 0; k < 4 && base + k < hs_req.size(); k++) begin
            chk("alt_who", 128'(hs_req[base+k]), 128'(k % 2));
            if (k > 0) chk("alt_gap", 128'(hs_cyc[base+k] - hs_cyc[base+k-1]), 128'd6);
        end

        // key and request offered together: key wins, requests stall until reload
        @(posedge clk); #1;
        req_valid[0]   = 1'b1;
        req_round[3:0] = 4'd10;
        key_valid      = 1'b1;
        key_in         = KEY2;
        @(negedge clk);
        chk("kv_wins_ready", 128'(key_ready), 128'h1);
        chk("kv_wins_nogrant", 128'(req_ready), 128'h0);
        @(posedge clk);
        cur_key = KEY2;
        #1 key_valid = 1'b0;
        @(negedge clk);
        chk("kv_loaded_drop", 128'(key_loaded), 128'h0);
        stall_bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (key_loaded) break;
            if (req_ready != '0) stall_bad++;
            @(negedge clk);
        end
        chk("stall_no_grant", 128'(stall_bad), 128'h0);
        chk("reload_done", 128'(key_loaded), 128'h1);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        wait_drain();
        chk("k2_r10_const", last_rsp_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // reset in the middle of a fetch (F2)
        @(posedge clk); #1;
        req_valid[0]   = 1'b1;
        req_round[3:0] = 4'd5;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (req_ready[0]) break;
        end
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_fetch_idx", 128'(ke_r_index), 128'd2);
        reset = 1'b1;
        sb.delete();
        #1 all_outs_zero("mid_fetch_reset");
        @(posedge clk); #1 reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_reset_unloaded", {key_loaded, key_ready}, 128'h1);

        load_key(KEY1, 1'b1);
        fetch(1, 4'd4);

        // key_expand never finishes
        hang = 1'b1;
        load_key(KEY2, 1'b0);
        n = 4;
        while (!key_err && n < 1200) begin
            @(negedge clk);
            n++;
        end
`ifdef KSC_WATCHDOG_EN
        chk("wdog_cycle", 128'(n), 128'd1027);
        @(negedge clk);
        chk("wdog_pulse_one", 128'(key_err), 128'h0);
        chk("wdog_idle", {key_loaded, key_ready}, 128'h1);
`else
        chk("no_wdog", 128'(n), 128'd1200);
        chk("still_waiting", {key_loaded, key_ready}, 128'h0);
`endif
        @(posedge clk); #1 reset = 1'b1;
        hang = 1'b0;
        @(posedge clk); #1 reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Controller in front of key_expand. Accepts a 128-bit cipher key over a valid/ready handshake and sequences key_expand's start pulse and 4-word load, then waits for done.
- After expansion, arbitrates round-key fetches from N_REQ requesters (encrypt/decrypt round engines) round-robin.
- Assembles each 128-bit round key from four 32-bit reads of key_expand's read port.

Parameters:
- N_REQ, 2: number of round-key requesters.
- WDOG_CYCLES, 1023: expansion watchdog limit; used only with KSC_WATCHDOG_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key_valid  in  1  new cipher key offered
- key_in  in  128  cipher key; bits [127:96] are word 0
- key_ready  out  1  controller can accept a key
- key_loaded  out  1  round keys valid in key_expand
- key_err  out  1  one-cycle pulse on watchdog expiry
- req_valid  in  N_REQ  per-requester fetch request
- req_round  in  4*N_REQ  requested round number, slice i = [4i+3:4i]
- req_ready  out  N_REQ  one-hot grant/handshake
- rsp_valid  out  N_REQ  one-hot, one-cycle response strobe
- rsp_key  out  128  assembled round key; word 0 in [127:96]
- rsp_err  out  1  qualifies rsp_valid: round out of range
- ke_start  out  1  to key_expand start
- ke_cipher_key  out  32  to key_expand cipher_key
- ke_round_key_num  out  4  to key_expand round_key_num
- ke_r_index  out  2  to key_expand r_index
- ke_round_key  in  32  from key_expand round_key (combinational read)
- ke_done  in  1  from key_expand done

Behaviour:
- Reset (async, active-high): both FSMs return to idle. Arbitration pointer = 0.
  - Outputs held low during reset: key_loaded, key_err, req_ready, rsp_valid, rsp_err, ke_start, ke_cipher_key, ke_round_key_num, ke_r_index.
  - rsp_key cleared to 0.
  - key_ready is 0 while reset is asserted, then 1 in the first cycle after release (LIDLE).
- Load FSM: LIDLE -> LSTART -> LW0 -> LW1 -> LW2 -> LW3 -> LEXP -> LRDY.
  - key_ready = 1 in LIDLE, and in LRDY while the fetch FSM is FIDLE. Otherwise 0.
  - On key_valid & key_ready: latch key_in, clear key_loaded, go to LSTART.
  - LSTART: ke_start = 1 for exactly one cycle.
  - LW0..LW3: ke_cipher_key = latched word k, one word per cycle, 4 consecutive cycles. ke_cipher_key is 0 in all other states.
  - LEXP: ke_done sampled only here. key_expand clears done on start, so a stale done cannot be seen. ke_done = 1 -> LRDY.
  - LRDY: key_loaded = 1.
- Fetch FSM: FIDLE -> F0 -> F1 -> F2 -> F3 -> FRSP -> FIDLE.
  - Grants happen only in FIDLE with load FSM in LRDY.
  - Round-robin: search starts at pointer. Winner g gets req_ready[g] = 1 combinationally in that cycle; handshake completes that cycle.
  - After a grant, pointer = (g+1) mod N_REQ.
  - Latch g and req_round[g].
  - Fk (k = 0..3): ke_round_key_num = latched round, ke_r_index = k. Capture ke_round_key into rsp_key[127-32k -: 32] at the clock edge.
  - FRSP: rsp_valid[g] = 1 for one cycle. rsp_key holds until the next capture.
  - Latency: handshake in cycle T -> rsp_valid in cycle T+5. Peak cadence: one fetch per 6 cycles.
  - No response backpressure; requesters must sink rsp_valid.
- Out-of-range round (req_round > 10): handshake normally, skip F0..F3, go directly to FRSP. rsp_err = 1, rsp_key = 0, latency T+1.
- Simultaneous key_valid and requests in LRDY/FIDLE: the key wins, key_ready = 1 and req_ready = 0. Requests stall until key_loaded returns.
- A new key is never accepted while a fetch is in flight.
- No grants while key_loaded = 0.
- Reset mid-load or mid-fetch: the operation is abandoned, no rsp_valid, key_loaded = 0, and a new key must be loaded.

Optional Feature:
- Macro: KSC_WATCHDOG_EN.
- Defined: a counter runs in LEXP. If ke_done has not arrived after WDOG_CYCLES cycles, go to LIDLE and pulse key_err for one cycle; key_loaded stays 0.
- Undefined: no counter. LEXP waits indefinitely and key_err is tied to 0.

Decomposition:
- Package aes_ks_pkg:
  - AES_NUM_ROUNDS = 10, MAX_ROUND = 4'd10
  - typedefs aes_word_t (32b), aes_key_t (128b)
  - load_state_t and fetch_state_t enums
- Sub-module ksc_rr_arbiter (N_REQ):
  - inputs: request vector, advance strobe
  - outputs: one-hot grant; holds the pointer

Test Plan:
- Load key 5468617473206D79204B756E67204675 -> ke_start high 1 cycle; ke_cipher_key = 54686174, 73206D79, 204B756E, 67204675 on next 4 cycles; key_loaded after ke_done.
- Req0 round 0 -> rsp_valid[0] at T+5, rsp_key = 5468617473206D79204B756E67204675. Req0 round 1 -> e232fcf191129188b159e4e6d679a293. Round 10 -> 28fddef86da4244accc0a4fe3b316f26.
- Req0 and Req1 both held continuously, rounds 3 and 7 -> grants alternate 0,1,0,1 at 6-cycle cadence; each rsp_valid matches its requester's round.
- Req1 round 12 -> rsp_valid[1] at T+1 with rsp_err = 1, rsp_key = 0; no ke_r_index sweep.
- key_valid with req_valid in same LRDY cycle -> key accepted, req_ready = 0, key_loaded drops. Reset asserted during F2 -> no rsp_valid, all outputs 0.
- KSC_WATCHDOG_EN, ke_done never asserted -> key_err pulse after 1023 LEXP cycles; key_ready = 1 next cycle.
